gpio_ctrl: RTL and testbench



---
 rtl/gpio_ctrl_if.sv | 22 ++
 rtl/gpio_ctrl.sv | 124 ++++++++++++
 tb/tb_gpio_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_if.sv
// Native valid/ready memory bus between the SoC core and a peripheral slave.
// One outstanding request; the master holds request fields stable until mem_ready.
interface gpio_ctrl_if #(
  parameter int unsigned ADDR_BITS = 5
) ();
  logic                 mem_valid;
  logic                 mem_ready;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_wstrb;
  logic [31:0]          mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO: per-pin direction, input synchroniser, selectable-polarity
// edge detection, sticky W1C interrupt status and a registered level interrupt.
module gpio_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_BITS   = 5
) (
  input  logic             clk,
  input  logic             reset,
  gpio_ctrl_if.slave       bus,
  input  logic [WIDTH-1:0] gpio_pin_in,
  output logic [WIDTH-1:0] gpio_pin_out,
  output logic [WIDTH-1:0] gpio_pin_oe,
  output logic             irq
);

  localparam int unsigned IdxW = ADDR_BITS - 2;

  localparam logic [IdxW-1:0] RegDataIn  = IdxW'(0);
  localparam logic [IdxW-1:0] RegDataOut = IdxW'(1);
  localparam logic [IdxW-1:0] RegDir     = IdxW'(2);
  localparam logic [IdxW-1:0] RegIrqEn   = IdxW'(3);
  localparam logic [IdxW-1:0] RegStatus  = IdxW'(4);
  localparam logic [IdxW-1:0] RegEdgeSel = IdxW'(5);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_last, sync_next;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [WIDTH-1:0] evt, clr, mask_w, wdat_w;
  logic             ready_q, irq_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             accept, is_wr;
  logic [IdxW-1:0]  idx;
  logic             unused_bits;

  assign sync_last = sync_q[SYNC_STAGES-1];
  // Value the last stage takes at this edge, so a DATA_IN read sees the freshest sample.
  assign sync_next = sync_q[SYNC_STAGES-2];

  assign evt = (edge_sel_q & sync_last & ~prev_q) | (~edge_sel_q & ~sync_last & prev_q);

  assign accept = bus.mem_valid & ~ready_q;
  assign is_wr  = accept & (|bus.mem_wstrb);
  assign idx    = bus.mem_addr[ADDR_BITS-1:2];
  assign wdat_w = bus.mem_wdata[WIDTH-1:0];

  assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata};

  always_comb begin
    mask_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask_w[i] = bus.mem_wstrb[i >> 3];
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    irq_en_d   = irq_en_q;
    edge_sel_d = edge_sel_q;
    clr        = '0;
    rdata_d    = '0;
    if (is_wr) begin
      case (idx)
        RegDataOut: data_out_d = (data_out_q & ~mask_w) | (wdat_w & mask_w);
        RegDir:     dir_d      = (dir_q & ~mask_w) | (wdat_w & mask_w);
        RegIrqEn:   irq_en_d   = (irq_en_q & ~mask_w) | (wdat_w & mask_w);
        RegStatus:  clr        = wdat_w & mask_w;
        RegEdgeSel: edge_sel_d = (edge_sel_q & ~mask_w) | (wdat_w & mask_w);
        default:    ;
      endcase
    end else if (accept) begin
      case (idx)
        RegDataIn:  rdata_d = 32'(sync_next);
        RegDataOut: rdata_d = 32'(data_out_q);
        RegDir:     rdata_d = 32'(dir_q);
        RegIrqEn:   rdata_d = 32'(irq_en_q);
        RegStatus:  rdata_d = 32'(status_q);
        RegEdgeSel: rdata_d = 32'(edge_sel_q);
        default:    rdata_d = '0;
      endcase
    end
    // A new event beats a simultaneous clear.
    status_d = (status_q & ~clr) | evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      prev_q     <= '0;
      data_out_q <= '0;
      dir_q      <= '0;
      irq_en_q   <= '0;
      status_q   <= '0;
      edge_sel_q <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_pin_in};
      prev_q     <= sync_last;
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      edge_sel_q <= edge_sel_d;
      ready_q    <= accept;
      rdata_q    <= rdata_d;
      irq_q      <= |(status_q & irq_en_q);
    end
  end

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign gpio_pin_out  = data_out_q;
  assign gpio_pin_oe   = dir_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: reads are scoreboarded against expected values
// queued at issue; pin, irq and handshake timing are checked inline per scenario.
module tb_gpio_ctrl;
  localparam int W  = 8;
  localparam int SS = 2;
  localparam int AB = 5;

  localparam logic [AB-1:0] ADataIn  = 5'h00;
  localparam logic [AB-1:0] ADataOut = 5'h04;
  localparam logic [AB-1:0] ADir     = 5'h08;
  localparam logic [AB-1:0] AIrqEn   = 5'h0C;
  localparam logic [AB-1:0] AStatus  = 5'h10;
  localparam logic [AB-1:0] AEdgeSel = 5'h14;
  localparam logic [AB-1:0] AUnmap   = 5'h1C;

  typedef struct {
    string       name;
    bit          is_read;
    logic [31:0] exp;
  } sb_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] pin_in = '0;
  logic [W-1:0] pin_out, pin_oe;
  logic         irq;
  int           n_tests = 0;
  int           n_fail = 0;
  sb_t          sb_q[$];

  always #5 clk = ~clk;

  gpio_ctrl_if #(.ADDR_BITS(AB)) bus ();

  gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(SS), .ADDR_BITS(AB)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .gpio_pin_in  (pin_in),
    .gpio_pin_out (pin_out),
    .gpio_pin_oe  (pin_oe),
    .irq          (irq)
  );

  // Scoreboard: every response pops the oldest outstanding request.
  always begin : monitor
    sb_t e;
    @(posedge clk);
    #1;
    if (bus.mem_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: mem_ready=1 with no request outstanding, required 0");
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) begin
          n_tests++;
          if (bus.mem_rdata !== e.exp) begin
            n_fail++;
            $display("FAIL %s: rdata=0x%08h required 0x%08h", e.name, bus.mem_rdata, e.exp);
          end
        end
      end
    end
  end

  // Returns at ready edge + 1 time unit with mem_valid already dropped.
  task automatic bus_xfer(input string name, input logic [AB-1:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [31:0] exp, output int cycles);
    sb_t e;
    bit  got;
    e.name = name;
    e.is_read = (wstrb == 4'b0000);
    e.exp = exp;
    got = 1'b0;
    cycles = 0;
    @(negedge clk);
    sb_q.push_back(e);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      #1;
      cycles++;
      got = (bus.mem_ready === 1'b1);
    end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no mem_ready after %0d cycles, required within 1", name, cycles);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic rd(input string name, input logic [AB-1:0] addr, input logic [31:0] exp);
    int c;
    bus_xfer(name, addr, 32'h0, 4'b0000, exp, c);
  endtask

  task automatic wr(input logic [AB-1:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int c;
    bus_xfer("wr", addr, data, strb, 32'h0, c);
  endtask

  task automatic test_reset();
    int c;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({irq, pin_oe, pin_out, bus.mem_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: irq/oe/out/ready=%b required all 0",
               {irq, pin_oe, pin_out, bus.mem_ready});
    end
    reset = 1'b0;
    for (int k = 0; k < 7; k++) begin
      bus_xfer($sformatf("reset_rd_%02h", k * 4), AB'(k * 4), 32'h0, 4'b0000, 32'h0, c);
      n_tests++;
      if (c != 1) begin
        n_fail++;
        $display("FAIL reset_latency_%0d: ready after %0d cycles, required 1", k, c);
      end
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_pulse_%0d: ready=%b rdata=0x%08h after pulse, required 0/0",
                 k, bus.mem_ready, bus.mem_rdata);
      end
    end
    n_tests++;
    if (pin_oe !== '0) begin
      n_fail++;
      $display("FAIL reset_oe: gpio_pin_oe=0x%02h required 0x00", pin_oe);
    end
  endtask

  task automatic test_write_partial();
    wr(ADir, 32'h0000_00FF, 4'b1111);
    n_tests++;
    if (pin_oe !== 8'hFF) begin
      n_fail++;
      $display("FAIL dir_oe: gpio_pin_oe=0x%02h required 0xff", pin_oe);
    end
    wr(ADataOut, 32'h0000_00A5, 4'b0001);
    n_tests++;
    if (pin_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL data_out_pin: gpio_pin_out=0x%02h required 0xa5", pin_out);
    end
    wr(ADataOut, 32'h0000_FF00, 4'b0010);
    wr(ADataOut, 32'h0000_FFFF, 4'b0010);
    n_tests++;
    if (pin_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL partial_strb: gpio_pin_out=0x%02h required 0xa5", pin_out);
    end
    wr(AUnmap, 32'hFFFF_FFFF, 4'b1111);
    rd("data_out_rb", ADataOut, 32'h0000_00A5);
    rd("dir_rb", ADir, 32'h0000_00FF);
    rd("unmapped_rb", AUnmap, 32'h0);
    wr(AEdgeSel, 32'hFFFF_FF3C, 4'b1111);
    rd("edge_sel_rb", AEdgeSel, 32'h0000_003C);
    wr(AEdgeSel, 32'h0, 4'b1111);
  endtask

  task automatic test_sync_edges();
    @(negedge clk);
    pin_in = 8'h01;
    rd("data_in_first", ADataIn, 32'h0000_0001);
    repeat (3) @(negedge clk);
    rd("status_no_rise", AStatus, 32'h0);
    pin_in = 8'h00;
    repeat (4) @(negedge clk);
    rd("status_fall", AStatus, 32'h0000_0001);
    wr(AStatus, 32'h0000_00FF, 4'b0001);
    rd("status_cleared", AStatus, 32'h0);
    @(negedge clk);
    pin_in = 8'h5A;
    rd("data_in_5a", ADataIn, 32'h0000_005A);
    repeat (3) @(negedge clk);
    pin_in = 8'h00;
    repeat (4) @(negedge clk);
    rd("status_fall_5a", AStatus, 32'h0000_005A);
    wr(AStatus, 32'h0000_00FF, 4'b0010);
    rd("status_w1c_strb", AStatus, 32'h0000_005A);
    wr(AStatus, 32'h0000_0042, 4'b0001);
    rd("status_w1c_part", AStatus, 32'h0000_0018);
    wr(AStatus, 32'h0000_00FF, 4'b0001);
    rd("status_empty", AStatus, 32'h0);
  endtask

  task automatic test_irq();
    wr(AIrqEn, 32'h0000_0001, 4'b0001);
    wr(AEdgeSel, 32'h0000_0001, 4'b0001);
    @(negedge clk);
    pin_in = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_early: irq=%b at status-set edge, required 0", irq);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise: irq=%b one cycle after status set, required 1", irq);
    end
    @(negedge clk);
    pin_in = 8'h00;
    repeat (3) @(negedge clk);
    wr(AStatus, 32'h0000_0001, 4'b0001);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_hold_on_clear: irq=%b at W1C edge, required 1", irq);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_fall: irq=%b cycle after W1C, required 0", irq);
    end
    rd("status_after_clear", AStatus, 32'h0);
  endtask

  // W1C lands on the same edge that a new rising event sets the bit.
  task automatic test_back_to_back();
    @(negedge clk);
    pin_in = 8'h01;
    repeat (4) @(negedge clk);
    pin_in = 8'h00;
    repeat (4) @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_setup_irq: irq=%b required 1", irq);
    end
    pin_in = 8'h01;
    @(negedge clk);
    wr(AStatus, 32'h0000_0001, 4'b0001);
    @(posedge clk);
    #1;
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL set_wins_irq: irq=%b after clear+event, required 1", irq);
    end
    rd("set_wins_status", AStatus, 32'h0000_0001);
    wr(AStatus, 32'h0000_0001, 4'b0001);
    rd("b2b_cleared", AStatus, 32'h0);
  endtask

  task automatic test_reset_mid();
    bit bad;
    wr(ADataOut, 32'h0000_003C, 4'b0001);
    wr(ADir, 32'h0000_000F, 4'b0001);
    @(negedge clk);
    pin_in = 8'h00;
    repeat (3) @(negedge clk);
    pin_in = 8'h01;
    repeat (5) @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup_irq: irq=%b required 1", irq);
    end
    bus.mem_valid = 1'b1;
    bus.mem_addr  = ADataOut;
    bus.mem_wdata = 32'h0000_00FF;
    bus.mem_wstrb = 4'b1111;
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({irq, bus.mem_ready, pin_out, pin_oe} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: irq/ready/out/oe=%b required all 0",
               {irq, bus.mem_ready, pin_out, pin_oe});
    end
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL mid_reset_ready: mem_ready pulsed during reset, required 0");
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'b0000;
    reset = 1'b0;
    rd("mid_data_out", ADataOut, 32'h0);
    rd("mid_dir", ADir, 32'h0);
    rd("mid_status", AStatus, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_partial();
    test_sync_edges();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
